// File: rtl/pilot_pkg.sv
// Shared types and constants for the pilot scheduler.
// Includes the optional pilot scrambler constants used when PILOT_SCRAMBLE_EN is defined.
package pilot_pkg;

  localparam int PKG_DW = 32;
  localparam int PKG_CW = 13;
  localparam int HW     = PKG_DW / 2;

  localparam logic [PKG_CW-1:0] PKG_DEF_FRAME_LEN = 13'd64;
  localparam logic [PKG_CW-1:0] PKG_DEF_PILOT_INT = 13'd8;
  localparam logic [PKG_DW-1:0] PKG_DEF_PILOT_VAL = 32'h7FFF_0000;

  // x^7 + x^4 + 1 in a left-shifting Fibonacci register: taps on bits 6 and 3
  localparam logic [6:0] LFSR_SEED = 7'h7F;
  localparam logic [6:0] LFSR_TAPS = 7'h48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PILOT = 2'd1,
    DATA  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PKG_CW-1:0] frame_length;
    logic [PKG_CW-1:0] pilot_interval;
    logic [PKG_DW-1:0] pilot_value;
  } cfg_t;

  // Two's-complement negate of one I or Q half; the most negative value saturates
  function automatic logic [HW-1:0] neg_sat(input logic [HW-1:0] x);
    logic [HW-1:0] r;
    if (x == {1'b1, {(HW-1){1'b0}}}) begin
      r = {1'b0, {(HW-1){1'b1}}};
    end else begin
      r = ~x + {{(HW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/pilot_lfsr.sv
// BPSK sign generator for pilot scrambling (used only when PILOT_SCRAMBLE_EN is defined).
// scr is the sign for the pilot being emitted now; reseed has priority over step.
module pilot_lfsr
  import pilot_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic reseed,
  input  logic step,
  output logic scr
);

  logic [6:0] lfsr_r;

  // Sign register: reseeded at frame start, advanced once per emitted pilot
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_r <= LFSR_SEED;
    end else if (reseed) begin
      lfsr_r <= LFSR_SEED;
    end else if (step) begin
      lfsr_r <= {lfsr_r[5:0], ^(lfsr_r & LFSR_TAPS)};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign scr = lfsr_r[6];

endmodule

// File: rtl/pilot_sched_ctrl.sv
// Pilot/data scheduler: merges input symbols and pilots into framed valid/ready output.
// Define PILOT_SCRAMBLE_EN to BPSK-scramble pilots with a per-frame reseeded LFSR.
module pilot_sched_ctrl
  import pilot_pkg::*;
#(
  parameter int              DW            = PKG_DW,
  parameter int              CW            = PKG_CW,
  parameter logic [CW-1:0]   DEF_FRAME_LEN = PKG_DEF_FRAME_LEN,
  parameter logic [CW-1:0]   DEF_PILOT_INT = PKG_DEF_PILOT_INT,
  parameter logic [DW-1:0]   DEF_PILOT_VAL = PKG_DEF_PILOT_VAL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [CW-1:0] cfg_frame_length,
  input  logic [CW-1:0] cfg_pilot_interval,
  input  logic [DW-1:0] cfg_pilot_value,
  input  logic          cfg_load,
  output logic          cfg_err,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_pilot,
  output logic          m_first,
  output logic          m_last,
  output logic [15:0]   frame_cnt,
  output logic          busy
);

  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] TWO  = {{(CW-2){1'b0}}, 2'b10};
  localparam cfg_t DEF_CFG = '{frame_length: DEF_FRAME_LEN,
                               pilot_interval: DEF_PILOT_INT,
                               pilot_value: DEF_PILOT_VAL};

  state_t        state_r;
  cfg_t          act_r;
  cfg_t          pend_r;
  logic [CW-1:0] sym_cnt_r;
  logic [CW-1:0] pil_cnt_r;
  logic [CW-1:0] pil_nxt_s;
  logic          adv_s;
  logic          load_s;
  logic          last_s;
  logic          start_s;
  logic          cfg_ok_s;
  logic          is_pilot_s;
  logic [DW-1:0] pilot_sym_s;

  // Per-cycle decode: output advance, symbol load, frame end and frame start
  always_comb begin
    adv_s      = !m_valid || m_ready;
    is_pilot_s = (state_r == PILOT);
    case (state_r)
      PILOT:   load_s = adv_s;
      DATA:    load_s = adv_s && s_valid;
      default: load_s = 1'b0;
    endcase
    last_s    = (sym_cnt_r == (act_r.frame_length - ONE));
    pil_nxt_s = (pil_cnt_r == (act_r.pilot_interval - ONE)) ? ZERO : (pil_cnt_r + ONE);
    start_s   = enable && ((state_r == IDLE) || (load_s && last_s));
    cfg_ok_s  = (cfg_frame_length >= TWO) && (cfg_pilot_interval != ZERO) &&
                (cfg_pilot_interval <= cfg_frame_length);
  end

  assign s_ready = (state_r == DATA) && adv_s;
  assign busy    = (state_r != IDLE);

`ifdef PILOT_SCRAMBLE_EN
  logic scr_s;

  pilot_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .reseed (start_s),
    .step   (load_s && is_pilot_s),
    .scr    (scr_s)
  );

  assign pilot_sym_s = scr_s ? {neg_sat(act_r.pilot_value[DW-1:DW/2]),
                                neg_sat(act_r.pilot_value[DW/2-1:0])}
                             : act_r.pilot_value;
`else
  assign pilot_sym_s = act_r.pilot_value;
`endif

  // Config shadowing, output register, position counters and frame FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      act_r     <= DEF_CFG;
      pend_r    <= DEF_CFG;
      sym_cnt_r <= ZERO;
      pil_cnt_r <= ZERO;
      m_data    <= {DW{1'b0}};
      m_valid   <= 1'b0;
      m_pilot   <= 1'b0;
      m_first   <= 1'b0;
      m_last    <= 1'b0;
      cfg_err   <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      if (cfg_load) begin
        if (cfg_ok_s) begin
          pend_r  <= '{frame_length: cfg_frame_length,
                       pilot_interval: cfg_pilot_interval,
                       pilot_value: cfg_pilot_value};
          cfg_err <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      // Apply reads pend_r before any same-cycle load lands in it
      if (start_s) begin
        act_r <= pend_r;
      end
      if (load_s) begin
        m_data  <= is_pilot_s ? pilot_sym_s : s_data;
        m_valid <= 1'b1;
        m_pilot <= is_pilot_s;
        m_first <= (sym_cnt_r == ZERO);
        m_last  <= last_s;
      end else if (adv_s) begin
        m_valid <= 1'b0;
      end
      if (start_s || (load_s && last_s)) begin
        sym_cnt_r <= ZERO;
        pil_cnt_r <= ZERO;
      end else if (load_s) begin
        sym_cnt_r <= sym_cnt_r + ONE;
        pil_cnt_r <= pil_nxt_s;
      end
      if (load_s && last_s) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      case (state_r)
        IDLE: state_r <= enable ? PILOT : IDLE;
        PILOT, DATA: begin
          if (load_s) begin
            if (last_s) begin
              state_r <= enable ? PILOT : IDLE;
            end else begin
              state_r <= (pil_nxt_s == ZERO) ? PILOT : DATA;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pilot_sched_ctrl.sv
// Self-checking bench for pilot_sched_ctrl: frame-level reference model fed by randomized
// handshakes. Expected pilot signs follow PILOT_SCRAMBLE_EN when it is defined.
module tb_pilot_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [12:0] cfg_frame_length;
  logic [12:0] cfg_pilot_interval;
  logic [31:0] cfg_pilot_value;
  logic        cfg_load;
  logic        cfg_err;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_pilot;
  logic        m_first;
  logic        m_last;
  logic [15:0] frame_cnt;
  logic        busy;

  pilot_sched_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_frame_length(cfg_frame_length), .cfg_pilot_interval(cfg_pilot_interval),
    .cfg_pilot_value(cfg_pilot_value), .cfg_load(cfg_load), .cfg_err(cfg_err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_pilot(m_pilot), .m_first(m_first), .m_last(m_last),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int          v_pct = 100;
  int          r_pct = 100;
  bit          inc_mode = 1'b1;
  logic [31:0] inc_val = 32'd1;
  int          stall_n = 0;
  bit          stall_act = 1'b0;
  logic [31:0] stall_val = 32'd0;

  // Reference model: frame position, configs, accepted-but-unsent input symbols
  int          pend_l = 64;
  int          pend_p = 8;
  logic [31:0] pend_v = 32'h7FFF_0000;
  int          act_l = 64;
  int          act_p = 8;
  logic [31:0] act_v = 32'h7FFF_0000;
  int          k = 0;
  int          pj = 0;
  int          frames = 0;
  logic [31:0] sent_q[$];
  bit          sgn_b[128];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: observed bound expired expected event", tag);
  endtask

  function automatic logic [31:0] pilot_exp(input logic [31:0] v, input int j);
    logic [31:0] r;
`ifdef PILOT_SCRAMBLE_EN
    int iv;
    int qv;
    r = v;
    if (sgn_b[j % 128]) begin
      iv = int'($signed(v[31:16]));
      qv = int'($signed(v[15:0]));
      iv = (iv == -32768) ? 32767 : -iv;
      qv = (qv == -32768) ? 32767 : -qv;
      r = {iv[15:0], qv[15:0]};
    end
`else
    r = v ^ {32{1'b0 & j[0]}};
`endif
    return r;
  endfunction

  task automatic check_out();
    logic [31:0] exp_d;
    bit          exp_p;
    if (k == 0) begin
      act_l = pend_l;
      act_p = pend_p;
      act_v = pend_v;
      pj    = 0;
    end
    exp_p = ((k % act_p) == 0);
    exp_d = 32'd0;
    if (exp_p) begin
      exp_d = pilot_exp(act_v, pj);
      pj++;
    end else if (sent_q.size() == 0) begin
      fail_now("src_queue_empty");
    end else begin
      exp_d = sent_q.pop_front();
    end
    chk("m_data", m_data, exp_d);
    chk("m_pilot", m_pilot, exp_p);
    chk("m_first", m_first, (k == 0));
    chk("m_last", m_last, (k == act_l - 1));
    if (k == act_l - 1) chk("frame_cnt", frame_cnt, (frames + 1) & 32'hFFFF);
    k++;
    if (k == act_l) begin
      k = 0;
      frames++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cfg_load = 1'b0;
    m_ready  = ($urandom_range(99) < r_pct);
    if (stall_n > 0 && (stall_act || (m_valid && !m_pilot && m_data == stall_val))) begin
      stall_act = 1'b1;
      m_ready   = 1'b0;
      stall_n--;
      chk("stall_m_data", m_data, stall_val);
      chk("stall_m_valid", m_valid, 1);
    end else begin
      stall_act = 1'b0;
    end
    s_valid = ($urandom_range(99) < v_pct);
    s_data  = inc_mode ? inc_val : $urandom();
    #1;
    if (rst) begin
      if (m_valid && !m_ready) chk("bp_s_ready", s_ready, 0);
      if (m_valid && m_ready) check_out();
      if (s_valid && s_ready) begin
        sent_q.push_back(s_data);
        inc_val++;
      end
    end
  endtask

  task automatic load(input int l, input int p, input logic [31:0] v, input bit ok);
    cfg_frame_length   = l[12:0];
    cfg_pilot_interval = p[12:0];
    cfg_pilot_value    = v;
    cfg_load           = 1'b1;
    cycle();
    chk("cfg_err", cfg_err, !ok);
    if (ok) begin
      pend_l = l;
      pend_p = p;
      pend_v = v;
    end
  endtask

  task automatic wait_pos(input int f, input int kk, input string tag);
    int b = 3000;
    while (!(frames == f && k == kk) && b > 0) begin
      cycle();
      b--;
    end
    if (!(frames == f && k == kk)) fail_now(tag);
  endtask

  task automatic wait_idle(input string tag);
    int b = 500;
    while (!(busy == 1'b0 && m_valid == 1'b0) && b > 0) begin
      cycle();
      b--;
    end
    if (!(busy == 1'b0 && m_valid == 1'b0)) fail_now(tag);
  endtask

  task automatic reset_checks();
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_pilot", m_pilot, 0);
    chk("rst_m_first", m_first, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    for (int n = 0; n < 128; n++) sgn_b[n] = (n < 7) ? 1'b1 : (sgn_b[n-7] ^ sgn_b[n-4]);
    rst = 1'b0; enable = 1'b0; cfg_load = 1'b0;
    cfg_frame_length = 13'd0; cfg_pilot_interval = 13'd0; cfg_pilot_value = 32'd0;
    s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b0;
    repeat (3) cycle();
    reset_checks();
    rst = 1'b1;
    cycle();

    // Directed: L=8 P=4, data 1,2,3..., stall 3 cycles on symbol 2, mid-frame reload
    load(8, 4, 32'hA5A5_1234, 1'b1);
    stall_val = 32'd2;
    stall_n   = 3;
    enable    = 1'b1;
    wait_pos(1, 2, "wait_frame2");
    load(6, 3, 32'h1234_8000, 1'b1);
    wait_pos(3, 0, "wait_frame3_end");

    // Randomized traffic, rejected loads keep the running config
    inc_mode = 1'b0;
    v_pct = 70;
    r_pct = 70;
    wait_pos(5, 2, "wait_rand");
    load(6, 0, 32'h0BAD_0BAD, 1'b0);
    load(8, 9, 32'h0BAD_0BAD, 1'b0);
    load(1, 1, 32'h0BAD_0BAD, 1'b0);
    wait_pos(7, 2, "wait_old_cfg");
    load(8, 8, 32'h8000_7FFF, 1'b1);

    // enable drop mid-frame: the frame completes, then idle
    wait_pos(9, 2, "wait_en_drop");
    enable = 1'b0;
    wait_idle("wait_idle");
    chk("idle_busy", busy, 0);
    chk("idle_s_ready", s_ready, 0);
    chk("idle_frame_cnt", frame_cnt, frames & 32'hFFFF);
    repeat (4) cycle();
    chk("idle_m_valid", m_valid, 0);

    // Reset mid-frame, then restart at a pilot with a new config
    enable = 1'b1;
    wait_pos(10, 5, "wait_rst_point");
    rst    = 1'b0;
    enable = 1'b0;
    repeat (2) cycle();
    reset_checks();
    sent_q.delete();
    k = 0; frames = 0;
    pend_l = 64; pend_p = 8; pend_v = 32'h7FFF_0000;
    rst = 1'b1;
    cycle();
    load(16, 4, 32'h7FFF_0000, 1'b1);
    enable = 1'b1;
    wait_pos(3, 0, "wait_l16_frames");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
